lfa_share_arbiter: RTL
======================

# lfa_share_arbiter

Round-robin controller that shares one 16-bit Ladner-Fischer adder instance among `N` requesters. It sits in front of the adder and drives its operand inputs. It tracks each issued operation through the adder's fixed pipeline latency with a tag shift register, then returns each sum to the requester that issued it on a shared response bus.

## Interface
- `N`, 4: number of requesters; 2..8.
- `ADD_LAT`, 1: adder latency in clock edges, from operands sampled to `add_sum`/`add_cout` valid; 1..4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N  per-requester operation request.
- `req_ready`  out  N  per-requester grant/accept, one-hot or zero.
- `req_a`  in  16*N  operand A; requester i on bits [16i+15:16i].
- `req_b`  in  16*N  operand B; same packing.
- `add_a`  out  16  to adder `A`.
- `add_b`  out  16  to adder `B`.
- `add_sum`  in  16  from adder `Sum`.
- `add_cout`  in  1  from adder `Cout`.
- `rsp_valid`  out  1  response strobe, one cycle per operation.
- `rsp_id`  out  $clog2(N)  index of requester owning the response.
- `rsp_sum`  out  16  result.
- `rsp_cout`  out  1  carry out.
- `busy`  out  1  any operation in flight.

## Operation
- Round-robin pointer `rr_ptr`:
  - Grant goes to the first i with `req_valid[i]`=1, searching from `rr_ptr` upward with wrap.
  - `req_ready` = grant, combinational from `req_valid` and `rr_ptr`. At most one bit is set.
  - No grant is made when `req_valid`=0.
- Transfer occurs on an edge where `req_valid[i]&req_ready[i]`.
  - The requester holds `valid`, `a` and `b` stable until the transfer.
  - `valid` must not drop before the transfer.
- On a transfer, `rr_ptr` <= (i+1) mod N. Otherwise `rr_ptr` holds.
- `add_a`/`add_b` = the granted requester's operands (combinational mux). Both are 0 when there is no grant.
  - The adder samples them on the same edge as the transfer.
- Tag pipeline `ADD_LAT` stages deep, each stage {vld, id}:
  - Stage 0 loads {transfer, i}; each stage shifts every edge.
  - Throughput is one operation per cycle with no bubbles.
- Response outputs:
  - `rsp_valid` = tail.vld; `rsp_id` = tail.id.
  - `rsp_sum` = `add_sum`; `rsp_cout` = `add_cout` (passthrough).
  - `rsp_sum`/`rsp_cout` are don't-care while `rsp_valid`=0.
- The response bus has no backpressure; consumers must accept every `rsp_valid` cycle.
- `busy` = OR of all tag vld bits.
- Arithmetic is unsigned 16-bit: {`rsp_cout`,`rsp_sum`} = A+B, 17-bit result.

## Timing
- Reset values:
  - `rr_ptr`=0 and all tag vld=0.
  - Outputs: `rsp_valid`=0, `rsp_id`=0, `busy`=0.
  - `req_ready`/`add_a`/`add_b` follow the combinational rules; all 0 while no `req_valid`.
- Latency: a transfer at edge k gives `rsp_valid`=1 in the cycle following edge k+ADD_LAT-1. With ADD_LAT=1, that is the cycle right after the transfer edge.
- Boundary conditions:
  - Simultaneous requests: `rr_ptr` decides; the requester just served has lowest priority next cycle.
  - Wrap-around: the search from `rr_ptr`=N-1 continues to 0.
  - Single continuous requester: granted every cycle.
- Reset mid-operation: all tag vld clear on the reset edge. In-flight results are discarded, with no `rsp_valid` even if the adder produces them. `req_ready` is forced to 0 while `rst`=1.
- A new transfer and a response in the same cycle are independent and both proceed.

## Configuration
- `LFA_ARB_OVF_EN` defined:
  - Adds output `rsp_ovf` (1 bit), the two's-complement overflow of the 16-bit add: (a15==b15)&&(sum15!=a15).
  - The tag pipeline additionally carries a15 and b15. `rsp_ovf` resets to 0.
- Undefined: no `rsp_ovf` port and no extra tag bits.

## Test plan
- Single op, ADD_LAT=1: requester 0 sends 0x0A0A+0x0505 → one cycle later `rsp_valid`=1, `rsp_id`=0, `rsp_sum`=0x0F0F, `rsp_cout`=0.
- Carry: requester 2 sends 0xFFFF+0x0001 → `rsp_sum`=0x0000, `rsp_cout`=1, `rsp_id`=2. With OVF_EN: `rsp_ovf`=0.
- Overflow: 0x8000+0x8000 → `rsp_sum`=0x0000, `rsp_cout`=1. With OVF_EN: `rsp_ovf`=1.
- Round-robin: all 4 requesters hold valid for 8 cycles → grants 0,1,2,3,0,1,2,3 back-to-back. Responses arrive in the same order with no gaps.
- Latency/ordering, ADD_LAT=3: requesters 1 then 3 on consecutive cycles → responses on consecutive cycles 3 cycles later, with `rsp_id` 1 then 3. `busy`=1 throughout.
- Reset mid-flight, ADD_LAT=3: assert `rst` one cycle after a transfer → no `rsp_valid` afterwards, `busy`=0, and the next grant starts from requester 0.

Source files
------------

// File: rtl/lfa_share_arbiter_if.sv
// lfa_share_arbiter_if: requester, adder and response signals of the shared-adder arbiter.
interface lfa_share_arbiter_if #(
  parameter int N = 4
);
  localparam int IW = $clog2(N);
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic add_cout;
  logic rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [15:0] rsp_sum;
  logic rsp_cout;
  logic busy;
`ifdef LFA_ARB_OVF_EN
  logic rsp_ovf;
`endif
  modport master (
    output req_valid, req_a, req_b, add_sum, add_cout,
    input req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
`ifdef LFA_ARB_OVF_EN
    , input rsp_ovf
`endif
  );
  modport slave (
    input req_valid, req_a, req_b, add_sum, add_cout,
    output req_ready, add_a, add_b, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
`ifdef LFA_ARB_OVF_EN
    , output rsp_ovf
`endif
  );
endinterface

// File: rtl/lfa_share_arbiter.sv
// lfa_share_arbiter: round-robin sharing of one pipelined 16-bit adder among N requesters.
// Define LFA_ARB_OVF_EN to add the rsp_ovf signed-overflow output.
module lfa_share_arbiter #(
  parameter int N = 4,
  parameter int ADD_LAT = 1
) (
  input logic clk,
  input logic rst,
  lfa_share_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam int T = ADD_LAT - 1;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, gnt_id, idx;
  logic gnt_vld;
  logic [15:0] a_mux, b_mux;
  logic [ADD_LAT-1:0] vld_q, vld_d;
  logic [ADD_LAT-1:0][IW-1:0] id_q, id_d;
`ifdef LFA_ARB_OVF_EN
  logic [ADD_LAT-1:0][1:0] sg_q, sg_d;
`endif
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id = '0;
    idx = '0;
    vld_d = '0;
    id_d = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % N);
      if (!gnt_vld && bus.req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id = idx;
      end
    end
    gnt_vld = gnt_vld && !rst;
    a_mux = gnt_vld ? bus.req_a[{gnt_id, 4'h0} +: 16] : '0;
    b_mux = gnt_vld ? bus.req_b[{gnt_id, 4'h0} +: 16] : '0;
    rr_ptr_d = gnt_vld ? ((gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1)) : rr_ptr_q;
    vld_d[0] = gnt_vld;
    id_d[0] = gnt_id;
    for (int s = 1; s < ADD_LAT; s++) begin
      vld_d[s] = vld_q[s-1];
      id_d[s] = id_q[s-1];
    end
  end
  assign bus.req_ready = gnt_vld ? (N'(1) << gnt_id) : '0;
  assign bus.add_a = a_mux;
  assign bus.add_b = b_mux;
  assign bus.rsp_valid = vld_q[T];
  assign bus.rsp_id = id_q[T];
  assign bus.rsp_sum = bus.add_sum;
  assign bus.rsp_cout = bus.add_cout;
  assign bus.busy = |vld_q;
`ifdef LFA_ARB_OVF_EN
  // operand sign bits ride along with the tag so overflow lines up with add_sum
  always_comb begin
    sg_d = '0;
    sg_d[0] = {a_mux[15], b_mux[15]};
    for (int s = 1; s < ADD_LAT; s++) sg_d[s] = sg_q[s-1];
  end
  assign bus.rsp_ovf = vld_q[T] && (sg_q[T][1] == sg_q[T][0]) && (bus.add_sum[15] != sg_q[T][1]);
  always_ff @(posedge clk) begin
    if (rst) sg_q <= '0;
    else sg_q <= sg_d;
  end
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      vld_q <= '0;
      id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q <= vld_d;
      id_q <= id_d;
    end
  end
endmodule
